// File: rtl/tile_move_checker_if.sv
// Request/response and map-BRAM bundle between the player stage and tile_move_checker.
// The slave side is the checker; the master side is the player stage plus the BRAM.
interface tile_move_checker_if;
  logic        ask_move;
  logic [3:0]  ask_x;
  logic [3:0]  ask_y;
  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic [18:0] bRAM_map_addr;
  logic [15:0] bRAM_map_data;
  logic        resp_valid;
  logic        accept_move;
  logic [3:0]  goto_x;
  logic [3:0]  goto_y;
  logic [3:0]  key_count;

  modport slave (
    input  ask_move, ask_x, ask_y, player_x, player_y, bRAM_map_data,
    output bRAM_map_addr, resp_valid, accept_move, goto_x, goto_y, key_count
  );

  modport master (
    output ask_move, ask_x, ask_y, player_x, player_y, bRAM_map_data,
    input  bRAM_map_addr, resp_valid, accept_move, goto_x, goto_y, key_count
  );
endinterface

// File: rtl/tile_move_checker.sv
// Validates a one-tile player move against the tile map in BRAM and tracks held keys.
// Every output is registered; a decision is a one-cycle resp_valid pulse.
module tile_move_checker #(
  parameter logic [18:0] MAP_BASE = 19'h00000,
  parameter int unsigned MAP_W    = 16,
  parameter int unsigned MAP_H    = 16,
  parameter int unsigned READ_LAT = 2
) (
  input  logic                clk,
  input  logic                sys_rst,
  tile_move_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WAIT   = 2'd2,
    DECIDE = 2'd3
  } state_t;

  localparam logic [4:0]  MAP_W5   = 5'(MAP_W);
  localparam logic [4:0]  MAP_H5   = 5'(MAP_H);
  localparam logic [18:0] MAP_W19  = 19'(MAP_W);
  localparam logic [2:0]  LAT_LAST = 3'(READ_LAT - 1);

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  ask_x_q, ask_x_d;
  logic [3:0]  ask_y_q, ask_y_d;
  logic [3:0]  ply_x_q, ply_x_d;
  logic [3:0]  ply_y_q, ply_y_d;
  logic        reject_q, reject_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [18:0] addr_q, addr_d;
  logic        resp_valid_q, resp_valid_d;
  logic        accept_q, accept_d;
  logic [3:0]  goto_x_q, goto_x_d;
  logic [3:0]  goto_y_q, goto_y_d;
  logic [3:0]  key_q, key_d;

  logic [4:0]  dist_s;
  logic        in_range_s;
  logic [18:0] req_addr_s;
  logic        dec_accept_s;
  logic [3:0]  dec_gx_s;
  logic [3:0]  dec_gy_s;
  logic [3:0]  dec_key_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^data_q[7:4];

  // Range/adjacency test and tile address, both from the live request inputs.
  always_comb begin
    dist_s     = {1'b0, abs_diff(bus.ask_x, bus.player_x)} +
                 {1'b0, abs_diff(bus.ask_y, bus.player_y)};
    in_range_s = ({1'b0, bus.ask_x} < MAP_W5) && ({1'b0, bus.ask_y} < MAP_H5) &&
                 (dist_s == 5'd1);
    req_addr_s = MAP_BASE + ({15'd0, bus.ask_y} * MAP_W19) + {15'd0, bus.ask_x};
  end

  // Tile-type decision; on reject the destination falls back to the player position.
  always_comb begin
    dec_accept_s = 1'b0;
    dec_gx_s     = ply_x_q;
    dec_gy_s     = ply_y_q;
    dec_key_s    = key_q;
    if (reject_q) begin
      dec_accept_s = 1'b0;
    end else begin
      case (data_q[3:0])
        4'd0: begin
          dec_accept_s = 1'b1;
          dec_gx_s     = ask_x_q;
          dec_gy_s     = ask_y_q;
        end
        4'd1: dec_accept_s = 1'b0;
        4'd2: begin
          if (key_q != 4'd0) begin
            dec_accept_s = 1'b1;
            dec_gx_s     = ask_x_q;
            dec_gy_s     = ask_y_q;
            dec_key_s    = key_q - 4'd1;
          end else begin
            dec_accept_s = 1'b0;
          end
        end
        4'd3: begin
          dec_accept_s = 1'b1;
          dec_gx_s     = ask_x_q;
          dec_gy_s     = ask_y_q;
          dec_key_s    = (key_q == 4'hF) ? key_q : key_q + 4'd1;
        end
        4'd4: begin
          // Teleport target is checked only against the map bounds, not adjacency.
          if (({1'b0, data_q[11:8]} < MAP_W5) && ({1'b0, data_q[15:12]} < MAP_H5)) begin
            dec_accept_s = 1'b1;
            dec_gx_s     = data_q[11:8];
            dec_gy_s     = data_q[15:12];
          end else begin
            dec_accept_s = 1'b0;
          end
        end
        default: dec_accept_s = 1'b0;
      endcase
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    ask_x_d      = ask_x_q;
    ask_y_d      = ask_y_q;
    ply_x_d      = ply_x_q;
    ply_y_d      = ply_y_q;
    reject_d     = reject_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    addr_d       = MAP_BASE;
    resp_valid_d = 1'b0;
    accept_d     = 1'b0;
    goto_x_d     = goto_x_q;
    goto_y_d     = goto_y_q;
    key_d        = key_q;
    case (state_q)
      IDLE: begin
        if (bus.ask_move) begin
          ask_x_d = bus.ask_x;
          ask_y_d = bus.ask_y;
          ply_x_d = bus.player_x;
          ply_y_d = bus.player_y;
          if (in_range_s) begin
            reject_d = 1'b0;
            addr_d   = req_addr_s;
            state_d  = READ;
          end else begin
            reject_d = 1'b1;
            state_d  = DECIDE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        addr_d  = addr_q;
        cnt_d   = 3'd0;
        state_d = WAIT;
      end
      WAIT: begin
        addr_d = addr_q;
        if (cnt_q == LAT_LAST) begin
          data_d  = bus.bRAM_map_data;
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DECIDE: begin
        resp_valid_d = 1'b1;
        accept_d     = dec_accept_s;
        goto_x_d     = dec_gx_s;
        goto_y_d     = dec_gy_s;
        key_d        = dec_key_s;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      ask_x_q      <= 4'd0;
      ask_y_q      <= 4'd0;
      ply_x_q      <= 4'd0;
      ply_y_q      <= 4'd0;
      reject_q     <= 1'b0;
      data_q       <= 16'd0;
      cnt_q        <= 3'd0;
      addr_q       <= MAP_BASE;
      resp_valid_q <= 1'b0;
      accept_q     <= 1'b0;
      goto_x_q     <= 4'd0;
      goto_y_q     <= 4'd0;
      key_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      ask_x_q      <= ask_x_d;
      ask_y_q      <= ask_y_d;
      ply_x_q      <= ply_x_d;
      ply_y_q      <= ply_y_d;
      reject_q     <= reject_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      accept_q     <= accept_d;
      goto_x_q     <= goto_x_d;
      goto_y_q     <= goto_y_d;
      key_q        <= key_d;
    end
  end

  assign bus.bRAM_map_addr = addr_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.accept_move   = accept_q;
  assign bus.goto_x        = goto_x_q;
  assign bus.goto_y        = goto_y_q;
  assign bus.key_count     = key_q;

endmodule
